// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: state encoding, default sizing
// and the lowest-index-wins priority helper.
package intr_ctrl_pkg;

  localparam int NSRC_DEF    = 4;
  localparam int MIN_GAP_DEF = 3;
  localparam int GAP_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  // Index of the lowest set bit; sources never exceed 8, so a fixed 8-bit view suffices.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
      else        idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Per-source rising-edge detector: optional two-flop synchronizer (INTR_SYNC_EN),
// previous-level flop and a rise pulse.
module irq_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic rise_o
);

  logic s;
  logic s_dly_q;
  logic armed_q;

`ifdef INTR_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for a fully asynchronous request line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = req_i;
`endif

  // A line already high when reset releases must drop low once before its edges count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_dly_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s_dly_q <= s;
      armed_q <= armed_q | ~s;
    end
  end

  assign rise_o = s & ~s_dly_q & armed_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller feeding the processor interrupt input: edge-latched pending
// register, fixed priority, REQ/SERVICE/GAP handshake. Optional macro: INTR_SYNC_EN.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC    = NSRC_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         irq_in,
  input  logic [NSRC-1:0]         mask,
  input  logic                    ack,
  input  logic                    done,
  output logic                    interrupt,
  output logic [$clog2(NSRC)-1:0] irq_id,
  output logic                    busy,
  output logic [NSRC-1:0]         pending
);

  localparam int IDW = $clog2(NSRC);

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  clr;
  logic [NSRC-1:0]  avail;
  logic             any_avail;
  logic             take;
  logic [IDW-1:0]   prio_idx;
  logic [IDW-1:0]   irq_id_q, irq_id_d;
  logic             interrupt_q, interrupt_d;
  logic             busy_q, busy_d;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_edge_det u_edge (
      .clk    (clk),
      .rst    (rst),
      .req_i  (irq_in[g]),
      .rise_o (rise[g])
    );
  end

  assign avail     = pending_q & ~mask;
  assign any_avail = |avail;
  assign prio_idx  = IDW'(lowest_set(8'(avail)));
  assign take      = (state_q == ST_REQ) && ack;
  // Set beats clear: an edge landing with the ack of the same source stays pending.
  assign clr       = take ? ({{(NSRC-1){1'b0}}, 1'b1} << irq_id_q) : {NSRC{1'b0}};
  assign pending_d = (pending_q & ~clr) | rise;

  // State register plus pending and gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= {GAP_W{1'b0}};
      pending_q <= {NSRC{1'b0}};
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic; ack wins over a same-cycle mask withdrawal.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (any_avail) state_d = ST_REQ;
        else           state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (ack)                 state_d = ST_SERVICE;
        else if (mask[irq_id_q]) state_d = ST_IDLE;
        else                     state_d = ST_REQ;
      end
      ST_SERVICE: begin
        if (done) begin
          state_d = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
          gap_d   = GAP_W'(MIN_GAP);
        end else begin
          state_d = ST_SERVICE;
        end
      end
      ST_GAP: begin
        // Leaving on the count of one lets IDLE raise the next request MIN_GAP+1 edges after done.
        gap_d = (gap_q != {GAP_W{1'b0}}) ? gap_q - 4'd1 : gap_q;
        if (gap_q <= 4'd1) state_d = ST_IDLE;
        else               state_d = ST_GAP;
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = {GAP_W{1'b0}};
      end
    endcase
  end

  // Output decode, computed from the next state so the outputs can be registered.
  always_comb begin
    interrupt_d = (state_d == ST_REQ);
    busy_d      = (state_d == ST_SERVICE) || (state_d == ST_GAP);
    if ((state_q == ST_IDLE) && any_avail) irq_id_d = prio_idx;
    else                                   irq_id_d = irq_id_q;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
      irq_id_q    <= {IDW{1'b0}};
    end else begin
      interrupt_q <= interrupt_d;
      busy_q      <= busy_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign interrupt = interrupt_q;
  assign busy      = busy_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl; request latency follows INTR_SYNC_EN.
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq_in = 4'd0;
  logic [3:0] mask = 4'd0;
  logic       ack = 1'b0;
  logic       done = 1'b0;
  logic       interrupt;
  logic [1:0] irq_id;
  logic       busy;
  logic [3:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  intr_ctrl #(.NSRC(4), .MIN_GAP(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask      (mask),
    .ack       (ack),
    .done      (done),
    .interrupt (interrupt),
    .irq_id    (irq_id),
    .busy      (busy),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(1); ack = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(1); done = 1'b0;
  endtask

  initial begin
    #2;
    check_eq("rst_int", 32'(interrupt), 32'd0);
    check_eq("rst_id", 32'(irq_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pend", 32'(pending), 32'd0);
    #10 rst = 1'b1;
    tick(3);

    // single request on source 2
    irq_in = 4'b0100;
    tick(LAT - 1);
    check_eq("single_early", 32'(interrupt), 32'd0);
    tick(1);
    check_eq("single_int", 32'(interrupt), 32'd1);
    check_eq("single_id", 32'(irq_id), 32'd2);
    irq_in = 4'b0000;
    pulse_ack();
    check_eq("ack_int", 32'(interrupt), 32'd0);
    check_eq("ack_pend", 32'(pending), 32'd0);
    check_eq("ack_busy", 32'(busy), 32'd1);
    pulse_done();
    check_eq("gap_busy", 32'(busy), 32'd1);
    tick(3);
    check_eq("gap_end_busy", 32'(busy), 32'd0);

    // priority: sources 3 and 1 together, then done/gap timing
    irq_in = 4'b1010;
    tick(LAT);
    check_eq("prio_int", 32'(interrupt), 32'd1);
    check_eq("prio_id", 32'(irq_id), 32'd1);
    pulse_ack();
    check_eq("prio_pend", 32'(pending), 32'b1000);
    pulse_done();
    tick(3);
    check_eq("gap_hold_int", 32'(interrupt), 32'd0);
    tick(1);
    check_eq("second_int", 32'(interrupt), 32'd1);
    check_eq("second_id", 32'(irq_id), 32'd3);

    // higher-priority edge during REQ must not preempt
    irq_in = 4'b1011;
    tick(1 + LAT);
    check_eq("nopreempt_id", 32'(irq_id), 32'd3);
    check_eq("nopreempt_pend", 32'(pending), 32'b1001);
    pulse_ack();
    check_eq("nopreempt_clr", 32'(pending), 32'b0001);
    pulse_done();
    tick(3);
    check_eq("gap2_hold_int", 32'(interrupt), 32'd0);
    tick(1);
    check_eq("gap2_int", 32'(interrupt), 32'd1);
    check_eq("gap2_id", 32'(irq_id), 32'd0);
    pulse_ack();
    pulse_done();
    irq_in = 4'b0000;
    tick(3);

    // mask withdrawal in REQ
    irq_in = 4'b0100;
    tick(LAT);
    check_eq("mask_pre_int", 32'(interrupt), 32'd1);
    mask = 4'b0100;
    tick(1);
    check_eq("mask_int", 32'(interrupt), 32'd0);
    check_eq("mask_pend", 32'(pending), 32'b0100);
    check_eq("mask_busy", 32'(busy), 32'd0);
    tick(1);
    check_eq("masked_idle", 32'(interrupt), 32'd0);
    mask = 4'b0000;
    tick(1);
    check_eq("unmask_int", 32'(interrupt), 32'd1);
    check_eq("unmask_id", 32'(irq_id), 32'd2);

    // set beats ack clear on the same source
    irq_in = 4'b0000;
    tick(1);
    irq_in = 4'b0100;
    tick(LAT - 2);
    pulse_ack();
    check_eq("setwins_pend", 32'(pending), 32'b0100);
    check_eq("setwins_int", 32'(interrupt), 32'd0);
    pulse_done();
    tick(3);
    check_eq("setwins_idle", 32'(interrupt), 32'd0);
    tick(1);
    check_eq("setwins_rereq", 32'(interrupt), 32'd1);
    pulse_ack();
    check_eq("svc_busy", 32'(busy), 32'd1);

    // async reset in SERVICE with the line held high
    #2 rst = 1'b0;
    #1;
    check_eq("arst_int", 32'(interrupt), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_pend", 32'(pending), 32'd0);
    #3 rst = 1'b1;
    tick(6);
    check_eq("level_no_trig", 32'(pending), 32'd0);
    pulse_ack();
    check_eq("stray_ack", 32'(interrupt), 32'd0);
    irq_in = 4'b0000;
    tick(2);
    irq_in = 4'b0100;
    tick(LAT);
    check_eq("retrig_int", 32'(interrupt), 32'd1);
    check_eq("retrig_id", 32'(irq_id), 32'd2);
    pulse_done();
    check_eq("stray_done", 32'(interrupt), 32'd1);

    // ack and mask rise together: ack wins
    mask = 4'b0100;
    ack  = 1'b1;
    tick(1);
    ack  = 1'b0;
    check_eq("ackmask_int", 32'(interrupt), 32'd0);
    check_eq("ackmask_busy", 32'(busy), 32'd1);
    check_eq("ackmask_pend", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
